// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 3-entry skid buffer,
// counting every delivered word.
module fifo_stream_reader #(
  parameter int DSIZE      = 32,
  parameter int COUNT_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  fifo_read,
  input  logic                  fifo_empty,
  input  logic [DSIZE-1:0]      fifo_data,
  output logic [DSIZE-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [COUNT_SIZE-1:0] word_count
);

  logic [1:0]            r_occ;
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic                  r_inflight;
  logic [COUNT_SIZE-1:0] r_word_count;
  logic [DSIZE-1:0]      r_buf [0:2];

  logic [2:0]            w_pending;
  logic                  w_valid;
  logic                  w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every outstanding read so a landing word always has room.
  always_comb begin
    w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
    fifo_read = !reset && enable && !fifo_empty && (w_pending < 3'd3);
    w_valid   = (r_occ != 2'd0);
    w_pop     = w_valid && out_ready;
    out_valid = w_valid;
    out_data  = w_valid ? r_buf[r_head] : '0;
    busy      = w_valid || r_inflight;
    word_count = r_word_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ        <= 2'd0;
      r_head       <= 2'd0;
      r_tail       <= 2'd0;
      r_inflight   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_inflight <= fifo_read;
      if (r_inflight) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head       <= next_ptr(r_head);
        r_word_count <= r_word_count + COUNT_SIZE'(1);
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Data storage carries no reset; out_data is masked by occupancy instead.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf[r_tail] <= fifo_data;
    end
  end

endmodule
